// File: rtl/laser_beacon_tx_pkg.sv
// Shared types and constants for the lap-timer beacon transmitter.
// Frame = SYNC (4 slots) + ID (2 slots/bit) + parity (2 slots) + GAP.
package laser_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP} laser_state_e;

  localparam logic [3:0] SYNC_PAT   = 4'b1110;
  localparam int         SYNC_SLOTS = 4;

  function automatic int frame_slots(input int id_bits, input int gap_slots);
    return SYNC_SLOTS + 2 * id_bits + 2 + gap_slots;
  endfunction

endpackage

// File: rtl/laser_beacon_tx_carrier_gen.sv
// Slot timer and carrier divider. 'mark' describes the cycle about to start,
// so the registered carrier lines up with the state the FSM is entering.
module carrier_gen #(
  parameter int CARRIER_DIV = 650,
  parameter int BIT_CYCLES  = 16
) (
  input  logic master_clk,
  input  logic rs,
  input  logic mark,
  input  logic slot_restart,
  output logic carrier,
  output logic slot_end
);

  localparam int SLOT = 2 * CARRIER_DIV * BIT_CYCLES;
  localparam int SW   = $clog2(SLOT);
  localparam int CW   = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [CW-1:0] car_cnt_q, car_cnt_d;
  logic          ph_lo_q, ph_lo_d;
  logic          carrier_q, carrier_d;

  assign slot_end = (slot_cnt_q == SW'(SLOT - 1));
  assign carrier  = carrier_q;

  always_comb begin
    slot_cnt_d = slot_cnt_q + SW'(1);
    car_cnt_d  = car_cnt_q + CW'(1);
    ph_lo_d    = ph_lo_q;
    // Every slot boundary realigns the carrier so each mark slot starts high.
    if (slot_restart || slot_end) begin
      slot_cnt_d = '0;
      car_cnt_d  = '0;
      ph_lo_d    = 1'b0;
    end else if (car_cnt_q == CW'(CARRIER_DIV - 1)) begin
      car_cnt_d = '0;
      ph_lo_d   = ~ph_lo_q;
    end
    carrier_d = mark & ~ph_lo_d;
  end

  always_ff @(posedge master_clk) begin
    if (rs) begin
      slot_cnt_q <= '0;
      car_cnt_q  <= '0;
      ph_lo_q    <= 1'b0;
      carrier_q  <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      car_cnt_q  <= car_cnt_d;
      ph_lo_q    <= ph_lo_d;
      carrier_q  <= carrier_d;
    end
  end

endmodule

// File: rtl/laser_beacon_tx.sv
// Beam-link transmitter: Manchester-coded beacon frames on a modulated carrier,
// repeated back-to-back while en is high.
module laser_beacon_tx
  import laser_pkg::*;
#(
  parameter int CARRIER_DIV = 650,
  parameter int BIT_CYCLES  = 16,
  parameter int ID_BITS     = 4,
  parameter int GAP_SLOTS   = 32
) (
  input  logic               master_clk,
  input  logic               rs,
  input  logic               en,
  input  logic [ID_BITS-1:0] beacon_id,
  output logic               laser_out,
  output logic               frame_start,
  output logic               busy,
  output logic [ID_BITS-1:0] cur_id
);

  localparam int DATA_SLOTS = 2 * ID_BITS;
  localparam int MAX_A      = (SYNC_SLOTS > DATA_SLOTS) ? SYNC_SLOTS : DATA_SLOTS;
  localparam int IDX_MAX    = (MAX_A > GAP_SLOTS) ? MAX_A : GAP_SLOTS;
  localparam int IDX_W      = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

  laser_state_e       state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_last;
  logic [ID_BITS-1:0] cur_id_q, cur_id_d;
  logic               frame_start_q, frame_start_d;
  logic               busy_q, busy_d;
  logic               start_frame;
  logic               slot_end;
  logic               mark_d;
  logic [3:0]         sync_sh;
  logic [ID_BITS-1:0] id_sh;

  always_comb begin
    idx_last = '0;
    unique case (state_q)
      SYNC:    idx_last = IDX_W'(SYNC_SLOTS - 1);
      DATA:    idx_last = IDX_W'(DATA_SLOTS - 1);
      PAR:     idx_last = IDX_W'(1);
      GAP:     idx_last = IDX_W'(GAP_SLOTS - 1);
      default: idx_last = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cur_id_d      = cur_id_q;
    frame_start_d = 1'b0;
    start_frame   = 1'b0;
    if (state_q == IDLE) begin
      start_frame = en;
    end else if (slot_end) begin
      if (idx_q == idx_last) begin
        idx_d = '0;
        unique case (state_q)
          SYNC:    state_d = DATA;
          DATA:    state_d = PAR;
          PAR:     state_d = GAP;
          GAP:     begin
                     state_d     = IDLE;
                     start_frame = en;
                   end
          default: state_d = IDLE;
        endcase
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
    // The ID is captured only here, so mid-frame beacon_id changes wait for the next SYNC.
    if (start_frame) begin
      state_d       = SYNC;
      idx_d         = '0;
      cur_id_d      = beacon_id;
      frame_start_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  // Mark/space of the slot being entered; within DATA/PAR idx[0] picks the Manchester half.
  always_comb begin
    sync_sh = SYNC_PAT << idx_d;
    id_sh   = cur_id_d << (idx_d >> 1);
    unique case (state_d)
      SYNC:    mark_d = sync_sh[3];
      DATA:    mark_d = id_sh[ID_BITS-1] ^ idx_d[0];
      PAR:     mark_d = (^cur_id_d) ^ idx_d[0];
      default: mark_d = 1'b0;
    endcase
  end

  always_ff @(posedge master_clk) begin
    if (rs) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cur_id_q      <= '0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cur_id_q      <= cur_id_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  carrier_gen #(
    .CARRIER_DIV (CARRIER_DIV),
    .BIT_CYCLES  (BIT_CYCLES)
  ) u_carrier (
    .master_clk   (master_clk),
    .rs           (rs),
    .mark         (mark_d),
    .slot_restart (state_q == IDLE),
    .carrier      (laser_out),
    .slot_end     (slot_end)
  );

  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign cur_id      = cur_id_q;

endmodule

// File: tb/tb_laser_beacon_tx.sv
// Directed bench for laser_beacon_tx with a frame-timeline reference model.
module tb_laser_beacon_tx;
  localparam int CD    = 2;
  localparam int BC    = 2;
  localparam int IDB   = 4;
  localparam int GS    = 4;
  localparam int SLOT  = 2 * CD * BC;
  localparam int FRAME = laser_pkg::frame_slots(IDB, GS) * SLOT;

  logic           master_clk = 1'b0;
  logic           rs, en;
  logic [IDB-1:0] beacon_id;
  logic           laser_out, frame_start, busy;
  logic [IDB-1:0] cur_id;

  int vecs = 0;
  int errs = 0;
  int m_t = -1;
  logic [IDB-1:0] m_id = '0;

  always #5 master_clk = ~master_clk;

  laser_beacon_tx #(
    .CARRIER_DIV (CD),
    .BIT_CYCLES  (BC),
    .ID_BITS     (IDB),
    .GAP_SLOTS   (GS)
  ) dut (
    .master_clk  (master_clk),
    .rs          (rs),
    .en          (en),
    .beacon_id   (beacon_id),
    .laser_out   (laser_out),
    .frame_start (frame_start),
    .busy        (busy),
    .cur_id      (cur_id)
  );

  function automatic logic exp_mark(input int s, input logic [IDB-1:0] id);
    logic [IDB-1:0] tmp;
    logic b;
    if (s < 4) return (s < 3);
    if (s < 4 + 2 * IDB) begin
      tmp = id >> (IDB - 1 - (s - 4) / 2);
      b = tmp[0];
      return (((s - 4) % 2) == 0) ? b : ~b;
    end
    if (s < 6 + 2 * IDB) begin
      b = ^id;
      return (s == 4 + 2 * IDB) ? b : ~b;
    end
    return 1'b0;
  endfunction

  function automatic logic exp_laser(input int t, input logic [IDB-1:0] id);
    if (t < 0) return 1'b0;
    return exp_mark(t / SLOT, id) && ((((t % SLOT) / CD) % 2) == 0);
  endfunction

  // Model: m_t = clocks since frame_start, -1 when idle.
  always @(posedge master_clk) begin
    if (rs) begin
      m_t = -1;
      m_id = '0;
    end else if (m_t < 0) begin
      if (en) begin m_t = 0; m_id = beacon_id; end
    end else begin
      m_t++;
      if (m_t == FRAME) begin
        if (en) begin m_t = 0; m_id = beacon_id; end
        else m_t = -1;
      end
    end
    #1;
    vecs++;
    if (laser_out !== exp_laser(m_t, m_id) || busy !== (m_t >= 0) ||
        frame_start !== (m_t == 0) || cur_id !== m_id) begin
      errs++;
      $display("FAIL cycle t=%0d laser/busy/fs/id: got %b %b %b %h want %b %b %b %h",
               m_t, laser_out, busy, frame_start, cur_id,
               exp_laser(m_t, m_id), (m_t >= 0), (m_t == 0), m_id);
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Starts at the negedge of frame clock 0, ends at the negedge of clock FRAME.
  task automatic run_frame(input int chg_at, input logic [IDB-1:0] new_id, input int drop_at,
                           input logic [IDB-1:0] exp_id, input logic [17:0] exp_slots,
                           input string nm, output logic [7:0] first8);
    logic [17:0] slots;
    slots  = '0;
    first8 = '0;
    for (int c = 0; c < FRAME; c++) begin
      if (c % SLOT == 0) slots = {slots[16:0], laser_out};
      if (c < SLOT) first8 = {first8[6:0], laser_out};
      if (c == FRAME - 1) check({nm, "_cur_id"}, 32'(cur_id), 32'(exp_id));
      if (c == chg_at) beacon_id = new_id;
      if (c == drop_at) en = 1'b0;
      @(negedge master_clk);
    end
    check({nm, "_slots"}, 32'(slots), 32'(exp_slots));
  endtask

  initial begin
    int nfs;
    logic [7:0] f8;
    rs = 1'b1; en = 1'b1; beacon_id = 4'b1010;
    repeat (3) begin
      @(negedge master_clk);
      check("rst_laser", 32'(laser_out), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_fs", 32'(frame_start), 0);
    end
    rs = 1'b0;
    @(negedge master_clk);
    check("A_fs", 32'(frame_start), 1);
    run_frame(100, 4'b0111, -1, 4'b1010, 18'b111010011001010000, "A", f8);
    check("A_carrier", 32'(f8), 32'h0000_00CC);

    check("B_fs", 32'(frame_start), 1);
    check("B_id", 32'(cur_id), 32'h7);
    run_frame(30, 4'b0000, -1, 4'b0111, 18'b111001101010100000, "B", f8);

    check("C_fs", 32'(frame_start), 1);
    check("C_id", 32'(cur_id), 0);
    run_frame(-1, 4'b0000, 20, 4'b0000, 18'b111001010101010000, "C", f8);
    check("C_busy_end", 32'(busy), 0);
    nfs = 0;
    repeat (20) begin
      nfs += int'(frame_start);
      @(negedge master_clk);
    end
    check("no_restart", 32'(nfs), 0);

    en = 1'b1; beacon_id = 4'b1100;
    @(negedge master_clk);
    check("D_fs", 32'(frame_start), 1);
    repeat (50) @(negedge master_clk);
    rs = 1'b1;
    @(negedge master_clk);
    check("rs_laser", 32'(laser_out), 0);
    check("rs_busy", 32'(busy), 0);
    check("rs_fs", 32'(frame_start), 0);
    rs = 1'b0; beacon_id = 4'b0001;
    @(negedge master_clk);
    check("E_fs", 32'(frame_start), 1);
    check("E_laser", 32'(laser_out), 1);
    run_frame(140, 4'b1111, -1, 4'b0001, 18'b111001010110100000, "E", f8);

    check("F_fs", 32'(frame_start), 1);
    check("F_busy", 32'(busy), 1);
    check("F_id", 32'(cur_id), 32'hF);
    run_frame(-1, 4'b0000, 0, 4'b1111, 18'b111010101010010000, "F", f8);
    check("F_end_busy", 32'(busy), 0);
    check("F_end_fs", 32'(frame_start), 0);

    repeat (3) @(negedge master_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
